// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between the 8-bit master and ahb_slave_mem.
// Macro: none in this file. The optional write-protect input (AHB_SLAVE_WRPROT_EN)
// is a plain port on ahb_slave_mem.
// Signals:
//   hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready  master -> slave
//   hreadyout, hresp, hrdata                                     slave -> master
interface ahb_slave_mem_if #(
  parameter int ADDR_W = 8
) ();
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [7:0]        hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [7:0]        hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder: byte-wide memory with programmable wait states and a
// two-cycle ERROR response for illegal size, out-of-range address or (optionally)
// writes while write-protected.
// Optional feature macro: AHB_SLAVE_WRPROT_EN adds the wprot input.
// Ports:
//   hclk     in  clock, rising edge
//   hresetn  in  asynchronous active-low reset
//   wprot    in  write protect (only with AHB_SLAVE_WRPROT_EN)
//   bus      ahb_slave_mem_if.slave (address/control/data in, hreadyout/hresp/hrdata out)
//
// state | meaning
// IDLE  | no data phase in progress, zero-wait OKAY
// WAIT  | OKAY data phase stalled, wait counter running
// DATA  | final OKAY data-phase cycle: read data driven / write committed
// ERR1  | first ERROR cycle (hreadyout=0, hresp=1)
// ERR2  | second ERROR cycle (hreadyout=1, hresp=1)
module ahb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input logic hclk,
  input logic hresetn,
`ifdef AHB_SLAVE_WRPROT_EN
  input logic wprot,
`endif
  ahb_slave_mem_if.slave bus
);

  localparam int         MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [7:0]        hrdata_q;
  logic [7:0]        mem [DEPTH];

  logic              can_accept;
  logic              accept;
  logic              addr_oor;
  logic              bad;
  logic              rd_active;
  logic [7:0]        mem_rd;
  logic              unused_bits;

  // Only cycles with hreadyout=1 end a data phase, so only they can take a new address.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept     = can_accept & bus.hsel & bus.hready & bus.htrans[1];
  assign addr_oor   = 32'(bus.haddr) >= 32'(DEPTH);

`ifdef AHB_SLAVE_WRPROT_EN
  assign bad = (bus.hsize != 3'b000) | addr_oor | (wprot & bus.hwrite);
`else
  assign bad = (bus.hsize != 3'b000) | addr_oor;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        bus.hresp = (state_q == S_ERR2);
        state_d   = S_IDLE;
        if (accept) begin
          if (bad) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WS_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_WAIT: begin
        bus.hreadyout = 1'b0;
        if (wcnt_q == 4'd0) state_d = S_DATA;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
        state_d       = S_ERR2;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= bus.haddr;
      wr_q   <= bus.hwrite;
    end
  end

  // Only in-range addresses ever reach DATA, so the low bits index the array.
  // Reset forces state_q out of DATA, which drops any write still pending.
  always_ff @(posedge hclk) begin
    if ((state_q == S_DATA) && wr_q) mem[addr_q[MEM_AW-1:0]] <= bus.hwdata;
  end

  assign mem_rd    = mem[addr_q[MEM_AW-1:0]];
  assign rd_active = (state_q == S_DATA) && !wr_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)       hrdata_q <= 8'h00;
    else if (rd_active) hrdata_q <= mem_rd;
  end

  // Read data comes straight from the array in the DATA cycle, so a write
  // committed at the end of the previous beat is already visible.
  assign bus.hrdata = rd_active ? mem_rd : hrdata_q;

  assign unused_bits = ^{bus.hburst, bus.htrans[0], addr_q};

endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;

  localparam int WS    = 1;
  localparam int DEPTH = 128;
`ifdef AHB_SLAVE_WRPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [2:0] size;
    logic [7:0] wdata;
    logic       prot;
  } beat_t;

  logic hclk;
  logic hresetn;
  logic wprot;

  ahb_slave_mem_if #(.ADDR_W(8)) bus ();

  assign bus.hready = bus.hreadyout;

  ahb_slave_mem #(.ADDR_W(8), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
`ifdef AHB_SLAVE_WRPROT_EN
    .wprot  (wprot),
`endif
    .bus    (bus.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int errors = 0;
  int checks = 0;

  // reference model: memory contents, which bytes are known, last read value
  logic [7:0] ref_mem [256];
  bit         ref_known [256];
  logic [7:0] ref_last;
  beat_t      q[$];
  logic [7:0] known_list[$];

  task automatic drive_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.haddr  = 8'h00;
    bus.hsize  = 3'b000;
    bus.hburst = 3'b000;
    wprot      = 1'b0;
  endtask

  task automatic drive_addr(input beat_t b, input bit first);
    bus.hsel   = 1'b1;
    bus.htrans = first ? 2'b10 : 2'b11;
    bus.haddr  = b.addr;
    bus.hwrite = b.wr;
    bus.hsize  = b.size;
    bus.hburst = 3'b001;
    wprot      = b.prot;
  endtask

  // Runs every beat in q fully pipelined and checks each data-phase cycle.
  task automatic run_beats(input string name);
    int n;
    bit bad;
    logic       exp_rdy, exp_resp;
    logic [7:0] exp_rd;
    @(posedge hclk); #1;
    drive_addr(q[0], 1'b1);
    for (int k = 0; k < q.size(); k++) begin
      @(posedge hclk); #1;
      bus.hwdata = q[k].wdata;
      if (k + 1 < q.size()) drive_addr(q[k+1], 1'b0);
      else                  drive_idle();
      bad = (q[k].size != 3'b000) || (int'(q[k].addr) >= DEPTH) ||
            (PROT_EN && q[k].wr && q[k].prot);
      n = bad ? 2 : WS + 1;
      for (int c = 0; c < n; c++) begin
        @(negedge hclk);
        exp_rdy  = (c == n - 1);
        exp_resp = bad;
        exp_rd   = (!bad && !q[k].wr && c == n - 1) ? ref_mem[q[k].addr] : ref_last;
        checks++;
        if (bus.hreadyout !== exp_rdy) begin
          errors++;
          $display("FAIL %s beat%0d cyc%0d hreadyout got %b want %b", name, k, c, bus.hreadyout, exp_rdy);
        end
        checks++;
        if (bus.hresp !== exp_resp) begin
          errors++;
          $display("FAIL %s beat%0d cyc%0d hresp got %b want %b", name, k, c, bus.hresp, exp_resp);
        end
        checks++;
        if (bus.hrdata !== exp_rd) begin
          errors++;
          $display("FAIL %s beat%0d cyc%0d hrdata got %h want %h", name, k, c, bus.hrdata, exp_rd);
        end
      end
      if (!bad && q[k].wr) begin
        if (!ref_known[q[k].addr]) known_list.push_back(q[k].addr);
        ref_mem[q[k].addr]   = q[k].wdata;
        ref_known[q[k].addr] = 1'b1;
      end else if (!bad) begin
        ref_last = ref_mem[q[k].addr];
      end
    end
    q.delete();
  endtask

  function automatic beat_t mk(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic [2:0] size = 3'b000, input logic prot = 1'b0);
    beat_t b;
    b.wr = wr; b.addr = addr; b.wdata = wdata; b.size = size; b.prot = prot;
    return b;
  endfunction

  task automatic check_idle_outputs(input string name, input logic [7:0] exp_rd);
    checks++;
    if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== exp_rd) begin
      errors++;
      $display("FAIL %s got rdy=%b resp=%b rdata=%h want rdy=1 resp=0 rdata=%h",
               name, bus.hreadyout, bus.hresp, bus.hrdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    bus.hwdata = 8'h00;
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_idle_outputs("reset_active", 8'h00);
    hresetn = 1'b1;
    ref_last = 8'h00;
    @(negedge hclk);
    check_idle_outputs("reset_released", 8'h00);
  endtask

  task automatic test_basic();
    q.push_back(mk(1'b1, 8'h10, 8'hA5));
    run_beats("basic_wr");
    q.push_back(mk(1'b0, 8'h10, 8'h00));
    run_beats("basic_rd");
  endtask

  task automatic test_idle();
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b01; bus.hwrite = 1'b1; bus.haddr = 8'h10;
    bus.hwdata = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      check_idle_outputs("idle_busy", ref_last);
    end
    @(posedge hclk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      check_idle_outputs("idle_unsel", ref_last);
    end
    drive_idle();
    q.push_back(mk(1'b0, 8'h10, 8'h00));
    run_beats("idle_readback");
  endtask

  task automatic test_back_to_back();
    q.push_back(mk(1'b1, 8'h20, 8'h01));
    q.push_back(mk(1'b1, 8'h21, 8'h02));
    q.push_back(mk(1'b0, 8'h20, 8'h00));
    q.push_back(mk(1'b0, 8'h21, 8'h00));
    q.push_back(mk(1'b1, 8'h22, 8'h77));
    q.push_back(mk(1'b0, 8'h22, 8'h00));
    run_beats("b2b");
  endtask

  task automatic test_bad_size();
    q.push_back(mk(1'b1, 8'h30, 8'h5E));
    q.push_back(mk(1'b1, 8'h30, 8'hEE, 3'b001));
    q.push_back(mk(1'b0, 8'h30, 8'h00));
    q.push_back(mk(1'b0, 8'h30, 8'h00, 3'b010));
    q.push_back(mk(1'b0, 8'h30, 8'h00));
    run_beats("bad_size");
  endtask

  task automatic test_out_of_range();
    q.push_back(mk(1'b1, 8'h7F, 8'hC3));
    q.push_back(mk(1'b0, 8'h80, 8'h00));
    q.push_back(mk(1'b0, 8'h7F, 8'h00));
    q.push_back(mk(1'b1, 8'hFF, 8'h11));
    q.push_back(mk(1'b0, 8'h7F, 8'h00));
    run_beats("range");
  endtask

  task automatic test_reset_in_wait();
    q.push_back(mk(1'b1, 8'h40, 8'h9B));
    run_beats("rstwait_init");
    @(posedge hclk); #1;
    drive_addr(mk(1'b1, 8'h40, 8'h00), 1'b1);
    @(posedge hclk); #1;
    drive_idle();
    bus.hwdata = 8'h5A;
    @(negedge hclk);
    checks++;
    if (bus.hreadyout !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_stall hreadyout got %b want 0", bus.hreadyout);
    end
    #1 hresetn = 1'b0;
    #1;
    ref_last = 8'h00;
    check_idle_outputs("rstwait_async", 8'h00);
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    q.push_back(mk(1'b0, 8'h40, 8'h00));
    run_beats("rstwait_readback");
  endtask

  task automatic test_wprot();
    q.push_back(mk(1'b1, 8'h05, 8'h42));
    q.push_back(mk(1'b1, 8'h05, 8'hFF, 3'b000, 1'b1));
    q.push_back(mk(1'b0, 8'h05, 8'h00, 3'b000, 1'b1));
    q.push_back(mk(1'b0, 8'h05, 8'h00));
    run_beats("wprot");
  endtask

  task automatic test_random();
    beat_t b;
    for (int burst = 0; burst < 6; burst++) begin
      int len = $urandom_range(2, 8);
      for (int i = 0; i < len; i++) begin
        b.wr    = $urandom_range(0, 1);
        b.wdata = 8'($urandom);
        b.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        b.prot  = ($urandom_range(0, 4) == 0);
        if (b.wr)                                   b.addr = 8'($urandom);
        else if ($urandom_range(0, 3) != 0)         b.addr = known_list[$urandom_range(0, known_list.size() - 1)];
        else                                        b.addr = 8'($urandom_range(DEPTH, 255));
        q.push_back(b);
      end
      run_beats("random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'h00;
      ref_known[i] = 1'b0;
    end
    ref_last = 8'h00;
    test_reset();
    test_basic();
    test_idle();
    test_back_to_back();
    test_bad_size();
    test_out_of_range();
    test_reset_in_wait();
    test_wprot();
    test_random();
    repeat (2) @(posedge hclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
